// File: rtl/rf_addr_sched.sv
// rf_addr_sched
//
// Frame-level scheduler for the sparse-weight register-file address
// generator. For each frame it walks every output position (h, w) and
// every filter column s (s innermost, then w, then h), starts one
// address-generation run per non-empty column, waits for that run to
// finish, and then offers a tagged batch-ready handshake to the PE loader.
// Empty columns are skipped at one cycle each, with no generator start.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge), synchronous active-low reset
//   i_frame_start     pulse, starts a frame when idle
//   i_abort           return to idle from any state, no frame_done
//   i_h_size/i_w_size frame size in output rows/columns, latched at start
//   i_len[s]          non-zero count per filter column, latched at start
//   o_gen_start       one-cycle start to the generator
//   o_gen_h/w/s       position and column for the generator run
//   o_gen_length      latched length of the current column
//   i_gen_finish      generator completion pulse
//   o_rf_valid        batch ready, held until i_rf_ready
//   i_rf_ready        downstream accept
//   o_rf_h/w/s        tag of the ready batch
//   o_busy            high whenever not idle
//   o_frame_done      one-cycle pulse at normal frame end
//
// All outputs are decoded from registered state, counters and latched
// configuration only, so the generator inputs stay stable from the issue
// cycle through the end of the handshake.

module rf_addr_sched #(
  parameter int H_MAX   = 32,
  parameter int W_MAX   = 32,
  parameter int S_NUM   = 3,
  parameter int LEN_MAX = 64,
  localparam int CW     = $clog2(H_MAX) + 1,
  localparam int LW     = $clog2(LEN_MAX) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_frame_start,
  input  logic          i_abort,
  input  logic [CW-1:0] i_h_size,
  input  logic [CW-1:0] i_w_size,
  input  logic [LW-1:0] i_len [0:S_NUM-1],
  output logic          o_gen_start,
  output logic [CW-1:0] o_gen_h,
  output logic [CW-1:0] o_gen_w,
  output logic [1:0]    o_gen_s,
  output logic [LW-1:0] o_gen_length,
  input  logic          i_gen_finish,
  output logic          o_rf_valid,
  input  logic          i_rf_ready,
  output logic [CW-1:0] o_rf_h,
  output logic [CW-1:0] o_rf_w,
  output logic [1:0]    o_rf_s,
  output logic          o_busy,
  output logic          o_frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HAND,
    DONE
  } state_t;

  localparam logic [1:0]    S_LAST  = 2'(S_NUM - 1);
  localparam logic [CW-1:0] H_LIMIT = CW'(H_MAX);
  localparam logic [CW-1:0] W_LIMIT = CW'(W_MAX);
  localparam logic [LW-1:0] L_LIMIT = LW'(LEN_MAX);

  state_t        state_q;
  state_t        state_d;

  logic [CW-1:0] h_q;
  logic [CW-1:0] w_q;
  logic [1:0]    s_q;
  logic [CW-1:0] h_size_q;
  logic [CW-1:0] w_size_q;
  logic [LW-1:0] len_q [0:S_NUM-1];

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] w_nxt;
  logic [1:0]    s_nxt;
  logic [CW-1:0] h_size_in;
  logic [CW-1:0] w_size_in;
  logic [LW-1:0] cur_len;
  logic          col_empty;
  logic          last_pos;

  logic          load_cfg;
  logic          cnt_clr;
  logic          cnt_adv;

  // Out-of-range sizes are clamped so a bad request can never walk
  // positions beyond what the array supports.
  always_comb begin
    h_size_in = (i_h_size > H_LIMIT) ? H_LIMIT : i_h_size;
    w_size_in = (i_w_size > W_LIMIT) ? W_LIMIT : i_w_size;
  end

  // Length of the current column. A compare loop rather than a direct
  // index keeps the select well-defined for any S_NUM up to 4.
  always_comb begin
    cur_len = '0;
    for (int i = 0; i < S_NUM; i++) begin
      if (s_q == 2'(i)) cur_len = len_q[i];
    end
  end

  assign col_empty = (cur_len == '0);

  // The last position is only meaningful while a frame is running, where
  // both latched sizes are known to be non-zero.
  assign last_pos = (s_q == S_LAST) &&
                    (w_q == w_size_q - CW'(1)) &&
                    (h_q == h_size_q - CW'(1));

  // Counter successor: s innermost, then w, then h; each wraps to 0, so
  // after the final position all counters come back to 0.
  always_comb begin
    s_nxt = s_q + 2'd1;
    w_nxt = w_q;
    h_nxt = h_q;
    if (s_q == S_LAST) begin
      s_nxt = '0;
      if (w_q == w_size_q - CW'(1)) begin
        w_nxt = '0;
        h_nxt = (h_q == h_size_q - CW'(1)) ? '0 : h_q + CW'(1);
      end else begin
        w_nxt = w_q + CW'(1);
      end
    end
  end

  // Next-state logic. Abort is checked first so that it beats a frame
  // start in the same cycle and discards an in-flight generator finish.
  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    cnt_clr  = 1'b0;
    cnt_adv  = 1'b0;
    if (i_abort) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_frame_start) begin
            load_cfg = 1'b1;
            cnt_clr  = 1'b1;
            if ((i_h_size == '0) || (i_w_size == '0)) state_d = DONE;
            else                                      state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (col_empty) begin
            cnt_adv = 1'b1;
            if (last_pos) state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (i_gen_finish) state_d = HAND;
        end
        HAND: begin
          if (i_rf_ready) begin
            cnt_adv = 1'b1;
            state_d = last_pos ? DONE : ISSUE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, position counters and latched frame configuration. Reset also
  // clears the configuration, which abort leaves in place.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      h_q      <= '0;
      w_q      <= '0;
      s_q      <= '0;
      h_size_q <= '0;
      w_size_q <= '0;
      for (int i = 0; i < S_NUM; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (load_cfg) begin
        h_size_q <= h_size_in;
        w_size_q <= w_size_in;
        for (int i = 0; i < S_NUM; i++) begin
          len_q[i] <= (i_len[i] > L_LIMIT) ? L_LIMIT : i_len[i];
        end
      end
      if (cnt_clr) begin
        h_q <= '0;
        w_q <= '0;
        s_q <= '0;
      end else if (cnt_adv) begin
        h_q <= h_nxt;
        w_q <= w_nxt;
        s_q <= s_nxt;
      end
    end
  end

  // Moore output decode.
  always_comb begin
    o_gen_start  = (state_q == ISSUE) && !col_empty;
    o_gen_h      = h_q;
    o_gen_w      = w_q;
    o_gen_s      = s_q;
    o_gen_length = cur_len;
    o_rf_valid   = (state_q == HAND);
    o_rf_h       = h_q;
    o_rf_w       = w_q;
    o_rf_s       = s_q;
    o_busy       = (state_q != IDLE);
    o_frame_done = (state_q == DONE);
  end

endmodule

// File: tb/tb_rf_addr_sched.sv
// tb_rf_addr_sched
//
// Testbench for rf_addr_sched. Each frame's expected sequence of batches
// is derived from the scheduling rules (nested walk over h, w, s with
// empty columns skipped), then the frame is driven cycle by cycle while a
// simple generator/downstream model supplies finish and ready pulses.

module tb_rf_addr_sched;

  localparam int CW    = 6;
  localparam int LW    = 7;
  localparam int S_NUM = 3;

  typedef struct {
    int h;
    int w;
    int s;
    int len;
    int skips;
  } batch_t;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_frame_start;
  logic          i_abort;
  logic [CW-1:0] i_h_size;
  logic [CW-1:0] i_w_size;
  logic [LW-1:0] i_len [0:S_NUM-1];
  logic          o_gen_start;
  logic [CW-1:0] o_gen_h;
  logic [CW-1:0] o_gen_w;
  logic [1:0]    o_gen_s;
  logic [LW-1:0] o_gen_length;
  logic          i_gen_finish;
  logic          o_rf_valid;
  logic          i_rf_ready;
  logic [CW-1:0] o_rf_h;
  logic [CW-1:0] o_rf_w;
  logic [1:0]    o_rf_s;
  logic          o_busy;
  logic          o_frame_done;

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;
  int start_seen  = 0;
  int done_seen   = 0;

  int            cfg_h;
  int            cfg_w;
  logic [LW-1:0] cfg_len [0:S_NUM-1];
  int            cfg_lat;
  int            cfg_ready;

  rf_addr_sched dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_frame_start (i_frame_start),
    .i_abort       (i_abort),
    .i_h_size      (i_h_size),
    .i_w_size      (i_w_size),
    .i_len         (i_len),
    .o_gen_start   (o_gen_start),
    .o_gen_h       (o_gen_h),
    .o_gen_w       (o_gen_w),
    .o_gen_s       (o_gen_s),
    .o_gen_length  (o_gen_length),
    .i_gen_finish  (i_gen_finish),
    .o_rf_valid    (o_rf_valid),
    .i_rf_ready    (i_rf_ready),
    .o_rf_h        (o_rf_h),
    .o_rf_w        (o_rf_w),
    .o_rf_s        (o_rf_s),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock once, and sample 1 time unit after
  // the edge. Start and done pulses are tallied for frame-level checks.
  task automatic applyStimulus(input logic fs, input logic ab,
                               input logic gf, input logic rdy);
    i_frame_start = fs;
    i_abort       = ab;
    i_gen_finish  = gf;
    i_rf_ready    = rdy;
    @(posedge i_clk);
    #1;
    if (o_gen_start === 1'b1) start_seen++;
    if (o_frame_done === 1'b1) done_seen++;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},  o_busy,       0);
    checkOutput({tag, "_start"}, o_gen_start,  0);
    checkOutput({tag, "_valid"}, o_rf_valid,   0);
    checkOutput({tag, "_done"},  o_frame_done, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkIdle(tag);
    checkOutput({tag, "_gen_h"},   o_gen_h,      0);
    checkOutput({tag, "_gen_w"},   o_gen_w,      0);
    checkOutput({tag, "_gen_s"},   o_gen_s,      0);
    checkOutput({tag, "_gen_len"}, o_gen_length, 0);
    checkOutput({tag, "_rf_h"},    o_rf_h,       0);
    checkOutput({tag, "_rf_w"},    o_rf_w,       0);
    checkOutput({tag, "_rf_s"},    o_rf_s,       0);
  endtask

  task automatic checkSkip();
    checkOutput("skip_start", o_gen_start,  0);
    checkOutput("skip_busy",  o_busy,       1);
    checkOutput("skip_valid", o_rf_valid,   0);
    checkOutput("skip_done",  o_frame_done, 0);
  endtask

  task automatic checkGen(input string tag, input batch_t b);
    checkOutput({tag, "_gen_h"},   o_gen_h,      b.h);
    checkOutput({tag, "_gen_w"},   o_gen_w,      b.w);
    checkOutput({tag, "_gen_s"},   o_gen_s,      b.s);
    checkOutput({tag, "_gen_len"}, o_gen_length, b.len);
  endtask

  task automatic checkTag(input string tag, input batch_t b);
    checkOutput({tag, "_valid"}, o_rf_valid,  1);
    checkOutput({tag, "_rf_h"},  o_rf_h,      b.h);
    checkOutput({tag, "_rf_w"},  o_rf_w,      b.w);
    checkOutput({tag, "_rf_s"},  o_rf_s,      b.s);
    checkOutput({tag, "_start"}, o_gen_start, 0);
  endtask

  // Run one complete frame from idle using cfg_* and check every cycle.
  // cfg_lat / cfg_ready of -1 select random generator latency / ready delay.
  task automatic runFrame(input string name);
    batch_t q[$];
    batch_t b;
    int     run_skips;
    int     lat;
    int     rdy_wait;
    logic   stray_start;

    run_skips = 0;
    for (int h = 0; h < cfg_h; h++) begin
      for (int w = 0; w < cfg_w; w++) begin
        for (int s = 0; s < S_NUM; s++) begin
          if (cfg_len[s] == '0) begin
            run_skips++;
          end else begin
            b.h = h; b.w = w; b.s = s; b.len = int'(cfg_len[s]);
            b.skips = run_skips;
            q.push_back(b);
            run_skips = 0;
          end
        end
      end
    end

    start_seen = 0;
    done_seen  = 0;
    i_h_size   = CW'(cfg_h);
    i_w_size   = CW'(cfg_w);
    for (int i = 0; i < S_NUM; i++) i_len[i] = cfg_len[i];
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Scramble the configuration inputs; the frame must use latched values.
    i_h_size = CW'($urandom_range(1, 4));
    i_w_size = CW'($urandom_range(1, 4));
    for (int i = 0; i < S_NUM; i++) i_len[i] = LW'($urandom_range(0, 64));

    if (cfg_h == 0 || cfg_w == 0) begin
      checkOutput({name, "_zero_done"},  o_frame_done, 1);
      checkOutput({name, "_zero_busy"},  o_busy,       1);
      checkOutput({name, "_zero_start"}, o_gen_start,  0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkIdle({name, "_zero_after"});
      checkOutput({name, "_zero_starts"}, start_seen, 0);
      return;
    end

    foreach (q[k]) begin
      b = q[k];
      for (int i = 0; i < b.skips; i++) begin
        checkSkip();
        applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      checkOutput({name, "_start"}, o_gen_start, 1);
      checkGen({name, "_issue"}, b);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      lat = (cfg_lat >= 0) ? cfg_lat : int'($urandom_range(0, 4));
      stray_start = 1'($urandom_range(0, 1));
      for (int i = 0; i < lat; i++) begin
        checkOutput({name, "_wait_start"}, o_gen_start, 0);
        checkOutput({name, "_wait_valid"}, o_rf_valid,  0);
        checkGen({name, "_wait"}, b);
        applyStimulus(stray_start && (i == 0), 1'b0, 1'b0, 1'b0);
      end
      checkOutput({name, "_fin_valid"}, o_rf_valid, 0);
      checkGen({name, "_fin"}, b);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      rdy_wait = (cfg_ready >= 0) ? cfg_ready : int'($urandom_range(0, 3));
      for (int i = 0; i < rdy_wait; i++) begin
        checkTag({name, "_hold"}, b);
        checkGen({name, "_hold"}, b);
        applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      checkTag({name, "_hand"}, b);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end

    for (int i = 0; i < run_skips; i++) begin
      checkSkip();
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    checkOutput({name, "_done"},       o_frame_done, 1);
    checkOutput({name, "_done_busy"},  o_busy,       1);
    checkOutput({name, "_done_start"}, o_gen_start,  0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkIdle({name, "_after"});
    checkOutput({name, "_starts"}, start_seen, q.size());
    checkOutput({name, "_dones"},  done_seen,  1);
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_frame_start = 1'b0;
    i_abort       = 1'b0;
    i_gen_finish  = 1'b0;
    i_rf_ready    = 1'b0;
    i_h_size      = '0;
    i_w_size      = '0;
    for (int i = 0; i < S_NUM; i++) i_len[i] = '0;

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAllZero("reset");
    i_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAllZero("post_reset");

    // Directed frame: 2x2, len {3,0,5}, finish 4 cycles after start.
    $display("[TB] directed 2x2 frame");
    cfg_h = 2; cfg_w = 2;
    cfg_len[0] = 7'd3; cfg_len[1] = 7'd0; cfg_len[2] = 7'd5;
    cfg_lat = 3; cfg_ready = 0;
    runFrame("basic");

    // Backpressure: ready held low for 10 cycles in every handshake.
    $display("[TB] backpressure frame");
    cfg_h = 1; cfg_w = 1;
    cfg_len[0] = 7'd1; cfg_len[1] = 7'd64; cfg_len[2] = 7'd0;
    cfg_lat = 1; cfg_ready = 10;
    runFrame("bp");

    // All columns empty: 6 skip cycles, then done.
    $display("[TB] all-empty frame");
    cfg_h = 1; cfg_w = 2;
    cfg_len[0] = 7'd0; cfg_len[1] = 7'd0; cfg_len[2] = 7'd0;
    cfg_lat = 0; cfg_ready = 0;
    runFrame("empty");

    // Zero-size frame.
    $display("[TB] zero-size frame");
    cfg_h = 0; cfg_w = 3;
    cfg_len[0] = 7'd2; cfg_len[1] = 7'd2; cfg_len[2] = 7'd2;
    runFrame("zero_h");

    // Abort and frame start in the same idle cycle: abort wins.
    i_h_size = 6'd1; i_w_size = 6'd1;
    for (int i = 0; i < S_NUM; i++) i_len[i] = 7'd2;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkIdle("abort_vs_start");

    // Abort during WAIT, then a late generator finish.
    $display("[TB] abort in WAIT");
    done_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_issue", o_gen_start, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_wait_busy", o_busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkIdle("abort_idle");
    checkOutput("abort_gen_h", o_gen_h, 0);
    checkOutput("abort_gen_s", o_gen_s, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkIdle("abort_late_fin");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkIdle("abort_late_fin2");
    checkOutput("abort_no_done", done_seen, 0);
    cfg_h = 1; cfg_w = 2;
    cfg_len[0] = 7'd4; cfg_len[1] = 7'd0; cfg_len[2] = 7'd9;
    cfg_lat = -1; cfg_ready = -1;
    runFrame("after_abort");

    // Reset pulse in the middle of a handshake.
    $display("[TB] reset mid-HAND");
    i_h_size = 6'd2; i_w_size = 6'd1;
    for (int i = 0; i < S_NUM; i++) i_len[i] = 7'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_second_s", o_gen_s, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_hand_valid", o_rf_valid, 1);
    checkOutput("rst_hand_s", o_rf_s, 1);
    i_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    checkAllZero("rst_mid");

    // Stray finish pulses while idle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'(i % 2 == 0), 1'b0);
      checkAllZero("idle_stray");
    end

    // Randomized frames.
    $display("[TB] randomized frames");
    for (int f = 0; f < 16; f++) begin
      cfg_h = $urandom_range(0, 3);
      cfg_w = $urandom_range(0, 3);
      for (int i = 0; i < S_NUM; i++) begin
        cfg_len[i] = ($urandom_range(0, 2) == 0) ? 7'd0 : LW'($urandom_range(1, 64));
      end
      cfg_lat = -1;
      cfg_ready = -1;
      runFrame("rand");
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/rf_addr_sched.md
# rf_addr_sched

Frame-level scheduler for the sparse-weight register-file address generator. On a frame start it walks every output position (h, w) and every filter column s, launches one address-generation run per non-empty column, waits for that run's completion, and presents a tagged batch-ready handshake to the downstream PE loader. It sits between the top-level convolution controller and the address-to-RF generator, and is the only block that drives the generator's start, position, column and length inputs.

## Interface
- H_MAX, 32: maximum output rows; CW = $clog2(H_MAX)+1 bits for row and column fields.
- W_MAX, 32: maximum output columns; must not exceed H_MAX.
- S_NUM, 3: filter columns per position; at most 4, so s fits 2 bits.
- LEN_MAX, 64: maximum non-zero entries per column; LW = $clog2(LEN_MAX)+1.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, active-low, synchronous.
- i_frame_start  in  1  pulse; begins a frame when idle.
- i_abort  in  1  synchronous abort to idle; has effect in every state.
- i_h_size  in  CW  output rows, 0..H_MAX.
- i_w_size  in  CW  output columns, 0..W_MAX.
- i_len[0:S_NUM-1]  in  LW each  non-zero count per filter column.
- o_gen_start  out  1  one-cycle start to the generator.
- o_gen_h, o_gen_w  out  CW  current position.
- o_gen_s  out  2  current filter column.
- o_gen_length  out  LW  latched i_len[s].
- i_gen_finish  in  1  generator completion pulse.
- o_rf_valid  out  1  batch ready.
- i_rf_ready  in  1  downstream accept.
- o_rf_h, o_rf_w  out  CW; o_rf_s  out  2  tag of the ready batch.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_done  out  1  one-cycle pulse at normal frame end.

## Operation
- States: IDLE, ISSUE, WAIT, HAND, DONE. All outputs are Moore-decoded from registered state and counters.
- IDLE:
  - On i_frame_start, latch i_h_size, i_w_size and i_len[*], and clear h, w, s to 0.
  - If either size is 0, go to DONE. Otherwise go to ISSUE.
  - i_frame_start is ignored in every other state.
- ISSUE:
  - If len[s] is 0, the column is skipped: advance the counters, spend one cycle per skipped column, and issue no start. If the skipped column was the last, go to DONE.
  - If len[s] is non-zero, assert o_gen_start for exactly this cycle, then go to WAIT.
- WAIT:
  - Stay until i_gen_finish, then go to HAND.
  - i_gen_finish is ignored in any other state; a stray pulse has no effect.
- HAND:
  - o_rf_valid is 1 and the tags equal the current h, w, s.
  - Valid and tags hold until i_rf_ready is sampled high.
  - On valid && ready, advance the counters. Go to DONE if that was the last position, otherwise to ISSUE.
- Advance order: s is innermost (0..S_NUM-1), then w (0..w_size-1), then h (0..h_size-1). Last position is h = h_size-1, w = w_size-1, s = S_NUM-1. Counters reset to 0 on wrap.
- DONE: o_frame_done is 1 for one cycle, then go to IDLE.
- Stable inputs to the generator: o_gen_h, o_gen_w, o_gen_s and o_gen_length are driven from the counters and the latched lengths. They are stable from ISSUE through the end of HAND, because the generator reads them combinationally for its whole run.
- i_abort: from any state, next state is IDLE. Counters clear, no frame_done, o_rf_valid drops. A generator finish still in flight is ignored.
- i_abort and i_frame_start in the same cycle: abort wins and the state stays IDLE.
- Reset value of all outputs: state IDLE, counters 0; every output 0, including o_busy, o_gen_start, o_rf_valid and o_frame_done.
- Reset during a frame behaves like abort but also clears the latched sizes and lengths.

## Timing
- i_frame_start at cycle 0 gives ISSUE at cycle 1 and o_gen_start at cycle 1 if len[0] is non-zero.
- i_gen_finish at cycle k gives o_rf_valid at cycle k+1.
- i_rf_ready high in the first valid cycle (k+1) gives the next ISSUE at k+2.
- Minimum cost per batch is 2 cycles plus generator latency. Each skipped column costs 1 cycle.
- Frame end: o_frame_done fires the cycle after the final handshake, or after the final skip. o_busy falls the cycle after o_frame_done.
- Frame start with a zero size: DONE at cycle 1 with o_frame_done at cycle 1; IDLE at cycle 2.

## Test plan
- h_size=2, w_size=2, len={3,0,5}, generator model finishing 4 cycles after start, ready always 1:
  - exactly 8 starts, with tags in order (0,0,0), (0,0,2), (0,1,0), … , (1,1,2);
  - o_gen_length alternates 3/5;
  - one o_frame_done pulse.
- Backpressure, with i_rf_ready held 0 for 10 cycles in HAND: valid and tags stay constant, no new start is issued, and progress resumes the cycle after ready rises.
- len={0,0,0}, h_size=1, w_size=2: no o_gen_start; o_frame_done arrives after 6 skip cycles; o_busy is high for exactly 7 cycles.
- h_size=0: o_frame_done at cycle 1, no starts. A second i_frame_start during WAIT of another frame is ignored, with no counter change.
- i_abort asserted in WAIT, then the generator's finish arrives 2 cycles later:
  - IDLE is reached the next cycle;
  - the finish produces no valid;
  - no o_frame_done;
  - a new frame starts cleanly from (0,0,0).
- i_rst_n low for 1 cycle mid-HAND: all outputs are 0 on the next cycle. Stray i_gen_finish pulses in IDLE produce no output activity.
